pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencing/hazard controller for the 5-stage MIPS pipeline.
- Produces write-enable, flush and bubble controls for the PC, the IF/ID latch and the ID/EX latch, plus a global pipeline enable for the EX/MEM and MEM/WB latches.
- Implements debug-unit run/step/halt sequencing, load-use stalls, taken-branch flushes and a drain-then-halt on the HALT instruction.
- Sits between the debug unit and the datapath latches.

Parameters:
REG_ADDR_W, 5, register address width
DRAIN_CYCLES, 3, cycles the pipeline is clocked after HALT leaves ID (EX, MEM, WB)
CNT_W, 32, width of cycle/stall counters

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  reset; asynchronous, active-high
i_run  input  1  level; continuous execution while high
i_step  input  1  one-cycle pulse; advance pipeline exactly one cycle
i_id_halt  input  1  instruction in ID decodes as HALT
i_branch_taken  input  1  branch/jump resolved taken in ID
i_idex_mem_read  input  1  instruction in EX is a load
i_idex_rt  input  REG_ADDR_W  destination of the load in EX
i_ifid_rs  input  REG_ADDR_W  rs of the instruction in ID
i_ifid_rt  input  REG_ADDR_W  rt of the instruction in ID
o_pipe_en  output  1  global enable for EX/MEM and MEM/WB latches and the register file write
o_pc_we  output  1  PC write enable
o_ifid_we  output  1  IF/ID latch write enable
o_ifid_flush  output  1  IF/ID loads NOP (dominates o_ifid_we)
o_idex_bubble  output  1  ID/EX loads control-zero bubble
o_state  output  3  current FSM state encoding
o_halted  output  1  high in HALTED
o_cycle_cnt  output  CNT_W  cycles with o_pipe_en=1
o_stall_cnt  output  CNT_W  cycles with a load-use stall

Behaviour:
- FSM states: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. Registered on posedge clk. On rst: state=IDLE, drain counter=0, both counters=0.
- Control outputs are combinational from state and hazard inputs (same-cycle effect). They must be stable before the following negedge, when the latches sample.
- IDLE: all control outputs are 0.
  - i_run=1 goes to RUN; else i_step=1 goes to STEP.
  - i_run has priority over i_step.
- STEP: active for exactly one cycle, then returns to IDLE. If HALT is accepted in that cycle, goes to DRAIN instead.
- RUN: active. Returns to IDLE on the first cycle after i_run falls; that cycle itself is still inactive. Goes to DRAIN on HALT acceptance.
- Active cycle (RUN or STEP), evaluated in priority order:
  1. Load-use hazard: i_idex_mem_read && i_idex_rt!=0 && (i_idex_rt==i_ifid_rs || i_idex_rt==i_ifid_rt).
     - Outputs: o_pipe_en=1, o_pc_we=0, o_ifid_we=0, o_idex_bubble=1, o_ifid_flush=0.
     - o_stall_cnt increments.
     - Branch and HALT in ID are ignored this cycle.
  2. i_id_halt (HALT accepted): o_pipe_en=1, o_pc_we=0, o_ifid_flush=1. HALT proceeds into ID/EX as a NOP. Next state is DRAIN with drain counter=DRAIN_CYCLES.
  3. i_branch_taken: o_pipe_en=1, o_pc_we=1, o_ifid_flush=1.
  4. Otherwise: o_pipe_en=1, o_pc_we=1, o_ifid_we=1, o_ifid_flush=0, o_idex_bubble=0.
- DRAIN: pipeline is clocked every cycle regardless of i_run/i_step. All hazard inputs are ignored.
  - Outputs: o_pipe_en=1, o_pc_we=0, o_ifid_we=0, o_idex_bubble=1.
  - Drain counter decrements each cycle. When it equals 1, goes to HALTED next.
  - Total time in DRAIN is exactly DRAIN_CYCLES cycles.
- HALTED: all controls 0, o_halted=1. Exits only via rst.
- o_cycle_cnt increments every cycle o_pipe_en=1 (including DRAIN). Both counters wrap modulo 2^CNT_W.
- rst asserted in any state, mid-stall or mid-drain: immediate return to IDLE and counters cleared. Outputs drop to 0 asynchronously.
- i_step held high for multiple cycles: a new step is taken on every cycle in which the FSM is in IDLE and i_step=1. The debug unit must pulse i_step.

Test Plan:
- Reset then i_run=1 with no hazards for 10 cycles → o_pc_we=o_ifid_we=o_pipe_en=1 each cycle, o_cycle_cnt=10, o_state=1.
- RUN with i_idex_mem_read=1, i_idex_rt=5, i_ifid_rs=5 for one cycle → o_pc_we=0, o_ifid_we=0, o_idex_bubble=1, o_stall_cnt=1. Repeat with i_idex_rt=0 → no stall.
- RUN with i_branch_taken=1 and simultaneous load-use → stall only, o_ifid_flush=0. Next cycle branch alone → o_ifid_flush=1, o_pc_we=1.
- i_id_halt=1 in RUN → o_ifid_flush=1, o_pc_we=0. Then exactly 3 DRAIN cycles with o_pipe_en=1. Then o_halted=1 and all enables 0 while i_run stays 1.
- From IDLE, three 1-cycle i_step pulses spaced 4 cycles apart → exactly 3 cycles with o_pipe_en=1, o_cycle_cnt=3.
- rst pulse asserted during DRAIN (counter=2) → outputs 0 immediately, o_state=0, counters=0. A later i_run restarts normally.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Sequencing and hazard controller for the 5-stage MIPS
//               pipeline (run/step/halt, load-use stall, branch flush, drain).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_run,
    input  logic                  i_step,
    input  logic                  i_id_halt,
    input  logic                  i_branch_taken,
    input  logic                  i_idex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_idex_rt,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs,
    input  logic [REG_ADDR_W-1:0] i_ifid_rt,
    output logic                  o_pipe_en,
    output logic                  o_pc_we,
    output logic                  o_ifid_we,
    output logic                  o_ifid_flush,
    output logic                  o_idex_bubble,
    output logic [2:0]            o_state,
    output logic                  o_halted,
    output logic [CNT_W-1:0]      o_cycle_cnt,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_run    = 3'd1;
    localparam logic [2:0] c_step   = 3'd2;
    localparam logic [2:0] c_drain  = 3'd3;
    localparam logic [2:0] c_halted = 3'd4;

    localparam int c_drain_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [c_drain_w-1:0] c_drain_load = c_drain_w'(DRAIN_CYCLES);
    localparam logic [c_drain_w-1:0] c_drain_one  = c_drain_w'(1);
    localparam logic [CNT_W-1:0]     c_cnt_one    = CNT_W'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_drain_w-1:0] r_drain_cnt;
    logic [c_drain_w-1:0] w_drain_nxt;
    logic [CNT_W-1:0]     r_cycle_cnt;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic                 w_load_use;
    logic                 w_stall;
    logic                 w_pipe_en;
    logic                 w_pc_we;
    logic                 w_ifid_we;
    logic                 w_ifid_flush;
    logic                 w_idex_bubble;

    // r0 is hardwired to zero, so a load into it never creates a hazard
    assign w_load_use = i_idex_mem_read && (i_idex_rt != '0) &&
                        ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_drain_cnt <= '0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            if (w_pipe_en) r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
            if (w_stall)   r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain_cnt;
        w_stall       = 1'b0;
        w_pipe_en     = 1'b0;
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;

        case (r_state)
            c_idle: begin
                if (i_run)       w_state_nxt = c_run;
                else if (i_step) w_state_nxt = c_step;
            end

            c_run, c_step: begin
                if ((r_state == c_step) || !i_run) w_state_nxt = c_idle;
                // RUN with i_run low is the inactive exit cycle
                if ((r_state == c_step) || i_run) begin
                    w_pipe_en = 1'b1;
                    if (w_load_use) begin
                        w_idex_bubble = 1'b1;
                        w_stall       = 1'b1;
                    end else if (i_id_halt) begin
                        w_ifid_flush = 1'b1;
                        w_state_nxt  = c_drain;
                        w_drain_nxt  = c_drain_load;
                    end else if (i_branch_taken) begin
                        w_pc_we      = 1'b1;
                        w_ifid_flush = 1'b1;
                    end else begin
                        w_pc_we   = 1'b1;
                        w_ifid_we = 1'b1;
                    end
                end
            end

            c_drain: begin
                w_pipe_en     = 1'b1;
                w_idex_bubble = 1'b1;
                w_drain_nxt   = r_drain_cnt - c_drain_one;
                if (r_drain_cnt == c_drain_one) w_state_nxt = c_halted;
            end

            c_halted: begin
                w_state_nxt = c_halted;
            end

            default: begin
                w_state_nxt = c_idle;
                w_drain_nxt = '0;
            end
        endcase
    end

    assign o_pipe_en     = w_pipe_en;
    assign o_pc_we       = w_pc_we;
    assign o_ifid_we     = w_ifid_we;
    assign o_ifid_flush  = w_ifid_flush;
    assign o_idex_bubble = w_idex_bubble;
    assign o_state       = r_state;
    assign o_halted      = (r_state == c_halted);
    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_run = 1'b0;
    logic        i_step = 1'b0;
    logic        i_id_halt = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic        i_idex_mem_read = 1'b0;
    logic [4:0]  i_idex_rt = '0;
    logic [4:0]  i_ifid_rs = '0;
    logic [4:0]  i_ifid_rt = '0;
    logic        o_pipe_en, o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble, o_halted;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_cnt, o_stall_cnt;

    typedef struct packed {
        logic [2:0] st;
        logic       pe;
        logic       pc;
        logic       we;
        logic       fl;
        logic       bub;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_cycle = '0;
    logic [31:0] m_stall = '0;

    pipeline_ctrl #(.REG_ADDR_W(5), .DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_step(i_step), .i_id_halt(i_id_halt),
        .i_branch_taken(i_branch_taken), .i_idex_mem_read(i_idex_mem_read),
        .i_idex_rt(i_idex_rt), .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
        .o_pipe_en(o_pipe_en), .o_pc_we(o_pc_we), .o_ifid_we(o_ifid_we),
        .o_ifid_flush(o_ifid_flush), .o_idex_bubble(o_idex_bubble), .o_state(o_state),
        .o_halted(o_halted), .o_cycle_cnt(o_cycle_cnt), .o_stall_cnt(o_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [2:0] st, input logic pe, pc, we, fl, bub);
        exp_t e;
        e.st = st; e.pe = pe; e.pc = pc; e.we = we; e.fl = fl; e.bub = bub;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(o_state), 32'd0);
        chk({tag, "_pipe_en"}, 32'(o_pipe_en), 32'd0);
        chk({tag, "_pc_we"}, 32'(o_pc_we), 32'd0);
        chk({tag, "_ifid_we"}, 32'(o_ifid_we), 32'd0);
        chk({tag, "_bubble"}, 32'(o_idex_bubble), 32'd0);
        chk({tag, "_flush"}, 32'(o_ifid_flush), 32'd0);
        chk({tag, "_cycle_cnt"}, o_cycle_cnt, 32'd0);
        chk({tag, "_stall_cnt"}, o_stall_cnt, 32'd0);
    endtask

    task automatic drive(input logic run, step, halt, br, mr,
                         input logic [4:0] idrt, rs, rt);
        i_run = run; i_step = step; i_id_halt = halt; i_branch_taken = br;
        i_idex_mem_read = mr; i_idex_rt = idrt; i_ifid_rs = rs; i_ifid_rt = rt;
    endtask

    // One pipeline cycle: drive after the edge, push expectation, sample at negedge
    task automatic cyc(input logic run, step, halt, br, mr,
                       input logic [4:0] idrt, rs, rt, input exp_t e);
        exp_t got;
        @(posedge clk); #1;
        drive(run, step, halt, br, mr, idrt, rs, rt);
        sb.push_back(e);
        @(negedge clk);
        chk("cycle_cnt", o_cycle_cnt, m_cycle);
        chk("stall_cnt", o_stall_cnt, m_stall);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("state", 32'(o_state), 32'(got.st));
            chk("pipe_en", 32'(o_pipe_en), 32'(got.pe));
            chk("pc_we", 32'(o_pc_we), 32'(got.pc));
            chk("ifid_we", 32'(o_ifid_we), 32'(got.we));
            chk("ifid_flush", 32'(o_ifid_flush), 32'(got.fl));
            chk("idex_bubble", 32'(o_idex_bubble), 32'(got.bub));
            chk("halted", 32'(o_halted), 32'(got.st == 3'd4));
            if (got.pe) m_cycle = m_cycle + 32'd1;
            if (got.bub && (got.st == 3'd1 || got.st == 3'd2)) m_stall = m_stall + 32'd1;
        end
    endtask

    task automatic reset_pulse(input string tag);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_all_zero(tag);
        m_cycle = '0;
        m_stall = '0;
        #1 rst = 1'b0;
    endtask

    exp_t E_ID, E_N, E_ST, E_BR, E_HLT, E_DR, E_HD;

    initial begin
        E_ID  = ex(3'd0, 0, 0, 0, 0, 0);
        E_N   = ex(3'd1, 1, 1, 1, 0, 0);
        E_ST  = ex(3'd1, 1, 0, 0, 0, 1);
        E_BR  = ex(3'd1, 1, 1, 0, 1, 0);
        E_HLT = ex(3'd1, 1, 0, 0, 1, 0);
        E_DR  = ex(3'd3, 1, 0, 0, 0, 1);
        E_HD  = ex(3'd4, 0, 0, 0, 0, 0);

        @(posedge clk); #1;
        chk_all_zero("reset");
        chk("reset_halted", 32'(o_halted), 32'd0);
        rst = 1'b0;

        // Continuous run, no hazards
        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_ID);
        repeat (10) cyc(1, 0, 0, 0, 0, 0, 0, 0, E_N);

        // Load-use variants
        cyc(1, 0, 0, 0, 1, 5, 5, 0, E_ST);
        chk("cycle_cnt_after_10", o_cycle_cnt, 32'd10);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, E_N);
        cyc(1, 0, 0, 0, 1, 7, 1, 7, E_ST);
        cyc(1, 0, 0, 0, 0, 5, 5, 0, E_N);

        // Branch vs stall priority
        cyc(1, 0, 0, 1, 1, 3, 3, 0, E_ST);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, E_BR);

        // HALT ignored under stall, then accepted, drain, halted
        cyc(1, 0, 1, 0, 1, 9, 0, 9, E_ST);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, E_HLT);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, E_DR);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, E_DR);
        cyc(1, 0, 0, 0, 1, 2, 2, 0, E_DR);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_HD);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, E_HD);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, E_HD);

        reset_pulse("rst_halted");

        // Three single steps spaced four cycles apart
        repeat (3) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, E_ID);
            cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(3'd2, 1, 1, 1, 0, 0));
            cyc(0, 0, 0, 0, 0, 0, 0, 0, E_ID);
            cyc(0, 0, 0, 0, 0, 0, 0, 0, E_ID);
        end
        chk("step_cycle_cnt", o_cycle_cnt, 32'd3);

        // Run falling: exit cycle inactive
        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_ID);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_N);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(3'd1, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, E_ID);

        // Step with a load-use stall, then step accepting HALT
        cyc(0, 1, 0, 0, 0, 0, 0, 0, E_ID);
        cyc(0, 0, 0, 0, 1, 4, 4, 0, ex(3'd2, 1, 0, 0, 0, 1));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, E_ID);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, E_ID);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, ex(3'd2, 1, 0, 0, 1, 0));
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, E_DR);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, E_HD);

        reset_pulse("rst_after_step_halt");

        // Reset mid-drain with drain counter at 2
        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_ID);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, E_HLT);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_DR);
        @(posedge clk); #1;
        chk("mid_drain_state", 32'(o_state), 32'd3);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_drain");
        m_cycle = '0;
        m_stall = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_ID);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_N);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, E_N);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(3'd1, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
